// File: rtl/wb_cpu_arbiter_if.sv
// Single Wishbone link (one master, one slave) as carried into and out of the CPU bus arbiter.
interface wb_cpu_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:2] addr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, addr, cti, bte, sel, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  cyc, stb, we, addr, cti, bte, sel, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/wb_cpu_arbiter.sv
// Two-master Wishbone arbiter: instruction fetch (m0) and load/store (m1) share one slave port.
// Ownership lasts a whole cyc span, ties go round-robin, and a watchdog errors out stuck strobes.
module wb_cpu_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    wb_cpu_arbiter_if.slave  m0,
    wb_cpu_arbiter_if.slave  m1,
    wb_cpu_arbiter_if.master s,
    output logic             timeout
);
    // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
    localparam int unsigned    WdW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned    WdEnd  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WdW-1:0] WdLast = WdW'(WdEnd);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           gnt_stb;
    logic           arb_en;
    logic           fire;

    // Strobe of the current owner; the watchdog only runs while it is high.
    always_comb begin
        gnt_stb = 1'b0;
        unique case (state_q)
            StGnt0:  gnt_stb = m0.stb;
            StGnt1:  gnt_stb = m1.stb;
            default: gnt_stb = 1'b0;
        endcase
    end

    // A real ack/err in the expiry cycle takes precedence over the watchdog.
    assign fire    = (TIMEOUT != 0) && gnt_stb && !s.ack && !s.err && (wd_q == WdLast);
    assign timeout = fire;

    // Arbitrate from idle, or as soon as the owner ends its bus cycle (no idle gap on handover).
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        arb_en  = (state_q == StIdle) ||
                  (state_q == StGnt0 && !m0.cyc) ||
                  (state_q == StGnt1 && !m1.cyc);
        if (arb_en) begin
            if (m0.cyc && (!m1.cyc || last_q)) begin
                state_d = StGnt0;
                last_d  = 1'b0;
            end else if (m1.cyc) begin
                state_d = StGnt1;
                last_d  = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Watchdog counts consecutive unanswered strobe cycles.
    always_comb begin
        wd_d = wd_q + 1'b1;
        if ((TIMEOUT == 0) || !gnt_stb || s.ack || s.err || fire) begin
            wd_d = '0;
        end
    end

    // State, round-robin pointer and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Request mux towards the slave and response steering back to the owner only.
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.addr  = '0;
        s.cti   = '0;
        s.bte   = '0;
        s.sel   = '0;
        s.wdata = '0;
        m0.ack  = 1'b0;
        m0.err  = 1'b0;
        m1.ack  = 1'b0;
        m1.err  = 1'b0;
        unique case (state_q)
            StGnt0: begin
                s.cyc   = m0.cyc;
                s.stb   = m0.stb;
                s.we    = m0.we;
                s.addr  = m0.addr;
                s.cti   = m0.cti;
                s.bte   = m0.bte;
                s.sel   = m0.sel;
                s.wdata = m0.wdata;
                m0.ack  = s.ack;
                m0.err  = s.err | fire;
            end
            StGnt1: begin
                s.cyc   = m1.cyc;
                s.stb   = m1.stb;
                s.we    = m1.we;
                s.addr  = m1.addr;
                s.cti   = m1.cti;
                s.bte   = m1.bte;
                s.sel   = m1.sel;
                s.wdata = m1.wdata;
                m1.ack  = s.ack;
                m1.err  = s.err | fire;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
endmodule

// File: tb/tb_wb_cpu_arbiter.sv
// Self-checking bench for wb_cpu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (owner / last winner / stalled-strobe count).
module tb_wb_cpu_arbiter;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic timeout;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: owner -1 = nobody, last = last master granted, wd = stalled cycles.
    int owner = -1;
    bit last  = 1'b1;
    int wd    = 0;

    wb_cpu_arbiter_if m0_if ();
    wb_cpu_arbiter_if m1_if ();
    wb_cpu_arbiter_if s_if ();

    wb_cpu_arbiter #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    function automatic logic mdl_stb();
        if (owner == 0) return m0_if.stb;
        if (owner == 1) return m1_if.stb;
        return 1'b0;
    endfunction

    function automatic logic mdl_fire();
        return mdl_stb() && !s_if.ack && !s_if.err && (wd == int'(TO) - 1);
    endfunction

    // Advance the model by one bus clock using the inputs present now, then move to posedge+1.
    task automatic tick();
        if (!rst) begin
            owner = -1;
            last  = 1'b1;
            wd    = 0;
        end else begin
            if (!mdl_stb() || s_if.ack || s_if.err || mdl_fire()) wd = 0;
            else wd++;
            if (owner < 0 || (owner == 0 && !m0_if.cyc) || (owner == 1 && !m1_if.cyc)) begin
                if (m0_if.cyc && m1_if.cyc) owner = last ? 0 : 1;
                else if (m0_if.cyc) owner = 0;
                else if (m1_if.cyc) owner = 1;
                else owner = -1;
                if (owner >= 0) last = (owner == 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.addr = '0;
        m0_if.cti = '0; m0_if.bte = '0; m0_if.sel = '0; m0_if.wdata = '0;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.addr = '0;
        m1_if.cti = '0; m1_if.bte = '0; m1_if.sel = '0; m1_if.wdata = '0;
        s_if.ack = 0; s_if.err = 0; s_if.rdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 0;
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_reset();
        rst = 0;
        drive_idle();
        m0_if.cyc = 1; m0_if.stb = 1; m1_if.cyc = 1; m1_if.stb = 1;
        m0_if.addr = 30'h3ff; s_if.ack = 1; s_if.err = 1; s_if.rdata = 32'h1234_5678;
        #2;
        checks++; if (s_if.cyc !== 1'b0) begin failures++; $display("FAIL reset_s_cyc got=%b exp=0", s_if.cyc); end
        checks++; if (s_if.stb !== 1'b0) begin failures++; $display("FAIL reset_s_stb got=%b exp=0", s_if.stb); end
        checks++; if (s_if.addr !== 30'h0) begin failures++; $display("FAIL reset_s_addr got=%h exp=0", s_if.addr); end
        checks++; if (m0_if.ack !== 1'b0) begin failures++; $display("FAIL reset_m0_ack got=%b exp=0", m0_if.ack); end
        checks++; if (m1_if.err !== 1'b0) begin failures++; $display("FAIL reset_m1_err got=%b exp=0", m1_if.err); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if (m0_if.rdata !== 32'h1234_5678) begin failures++; $display("FAIL reset_m0_rdata got=%h exp=12345678", m0_if.rdata); end
        checks++; if (m1_if.rdata !== 32'h1234_5678) begin failures++; $display("FAIL reset_m1_rdata got=%h exp=12345678", m1_if.rdata); end
        tick();
        drive_idle();
        rst = 1;
        tick();
    endtask

    task automatic test_single();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 0; m0_if.addr = 30'h400; m0_if.sel = 4'hf;
        @(negedge clk);
        checks++; if (s_if.cyc !== 1'b0) begin failures++; $display("FAIL single_latency got=%b exp=0", s_if.cyc); end
        tick();
        for (int n = 0; n < 3; n++) begin
            s_if.ack = (n == 2);
            s_if.rdata = 32'hCAFE_F00D;
            @(negedge clk);
            checks++; if (s_if.cyc !== 1'b1) begin failures++; $display("FAIL single_s_cyc got=%b exp=1", s_if.cyc); end
            checks++; if (s_if.addr !== 30'h400) begin failures++; $display("FAIL single_s_addr got=%h exp=400", s_if.addr); end
            checks++; if (m0_if.ack !== (n == 2)) begin failures++; $display("FAIL single_m0_ack got=%b exp=%b", m0_if.ack, n == 2); end
            checks++; if (m1_if.ack !== 1'b0) begin failures++; $display("FAIL single_m1_ack got=%b exp=0", m1_if.ack); end
            if (n == 2) begin
                checks++; if (m0_if.rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL single_m0_rdata got=%h exp=cafef00d", m0_if.rdata); end
            end
            tick();
        end
        drive_idle();
        @(negedge clk);
        checks++; if (s_if.cyc !== 1'b0) begin failures++; $display("FAIL single_release got=%b exp=0", s_if.cyc); end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 30'h111;
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.addr = 30'h222; m1_if.we = 1;
        tick();
        s_if.ack = 1;
        @(negedge clk);
        checks++; if (s_if.addr !== 30'h111) begin failures++; $display("FAIL tie_first_addr got=%h exp=111", s_if.addr); end
        checks++; if (m0_if.ack !== 1'b1) begin failures++; $display("FAIL tie_m0_ack got=%b exp=1", m0_if.ack); end
        checks++; if (m1_if.ack !== 1'b0) begin failures++; $display("FAIL tie_m1_ack_held got=%b exp=0", m1_if.ack); end
        tick();
        m0_if.cyc = 0; m0_if.stb = 0; s_if.ack = 0;
        tick();
        s_if.ack = 1;
        @(negedge clk);
        checks++; if (s_if.cyc !== 1'b1) begin failures++; $display("FAIL tie_handover_cyc got=%b exp=1", s_if.cyc); end
        checks++; if (s_if.addr !== 30'h222) begin failures++; $display("FAIL tie_handover_addr got=%h exp=222", s_if.addr); end
        checks++; if (s_if.we !== 1'b1) begin failures++; $display("FAIL tie_handover_we got=%b exp=1", s_if.we); end
        checks++; if (m1_if.ack !== 1'b1) begin failures++; $display("FAIL tie_m1_ack got=%b exp=1", m1_if.ack); end
        checks++; if (m0_if.ack !== 1'b0) begin failures++; $display("FAIL tie_m0_ack_after got=%b exp=0", m0_if.ack); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_round_robin();
        int seq[$];
        bit seen0 = 0;
        bit seen1 = 0;
        do_reset();
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            m0_if.cyc = !seen0; m0_if.stb = !seen0;
            m1_if.cyc = !seen1; m1_if.stb = !seen1;
            s_if.ack = 0;
            @(negedge clk);
            s_if.ack = s_if.stb;
            #1;
            seen0 = m0_if.ack;
            seen1 = m1_if.ack;
            if (seen0) seq.push_back(0);
            if (seen1) seq.push_back(1);
            tick();
        end
        checks++; if (seq.size() != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", seq.size()); end
        foreach (seq[i]) begin
            checks++; if (seq[i] != i % 2) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, seq[i], i % 2); end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_burst();
        logic [2:0] ecti;
        drive_idle();
        tick();
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.addr = 30'h300; m1_if.cti = 3'b010;
        tick();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 30'h055;
        for (int k = 0; k < 4; k++) begin
            ecti = (k == 3) ? 3'b111 : 3'b010;
            m1_if.addr = 30'h300 + 30'(k);
            m1_if.cti = ecti;
            s_if.ack = 1;
            @(negedge clk);
            checks++; if (s_if.addr !== 30'h300 + 30'(k)) begin failures++; $display("FAIL burst_addr[%0d] got=%h exp=%h", k, s_if.addr, 30'h300 + 30'(k)); end
            checks++; if (s_if.cti !== ecti) begin failures++; $display("FAIL burst_cti[%0d] got=%b exp=%b", k, s_if.cti, ecti); end
            checks++; if (m1_if.ack !== 1'b1) begin failures++; $display("FAIL burst_m1_ack[%0d] got=%b exp=1", k, m1_if.ack); end
            checks++; if (m0_if.ack !== 1'b0) begin failures++; $display("FAIL burst_m0_ack[%0d] got=%b exp=0", k, m0_if.ack); end
            tick();
        end
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.cti = 3'b000; s_if.ack = 0;
        tick();
        s_if.ack = 1;
        @(negedge clk);
        checks++; if (s_if.addr !== 30'h055) begin failures++; $display("FAIL burst_m0_after_addr got=%h exp=055", s_if.addr); end
        checks++; if (m0_if.ack !== 1'b1) begin failures++; $display("FAIL burst_m0_after_ack got=%b exp=1", m0_if.ack); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_watchdog();
        drive_idle();
        tick();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 30'h777;
        tick();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++; if (timeout !== (n == 7)) begin failures++; $display("FAIL wd_timeout[%0d] got=%b exp=%b", n, timeout, n == 7); end
            checks++; if (m0_if.err !== (n == 7)) begin failures++; $display("FAIL wd_m0_err[%0d] got=%b exp=%b", n, m0_if.err, n == 7); end
            checks++; if (m1_if.err !== 1'b0) begin failures++; $display("FAIL wd_m1_err[%0d] got=%b exp=0", n, m1_if.err); end
            tick();
        end
        drive_idle();
        tick();
        m0_if.cyc = 1; m0_if.stb = 1;
        tick();
        for (int n = 0; n < 8; n++) begin
            s_if.ack = (n == 7);
            @(negedge clk);
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wd_ack_timeout[%0d] got=%b exp=0", n, timeout); end
            if (n == 7) begin
                checks++; if (m0_if.ack !== 1'b1) begin failures++; $display("FAIL wd_ack_wins_ack got=%b exp=1", m0_if.ack); end
                checks++; if (m0_if.err !== 1'b0) begin failures++; $display("FAIL wd_ack_wins_err got=%b exp=0", m0_if.err); end
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        tick();
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.addr = 30'h500; m1_if.cti = 3'b010;
        tick();
        s_if.ack = 1;
        tick();
        m1_if.addr = 30'h501;
        #2;
        rst = 0;
        #1;
        checks++; if (s_if.cyc !== 1'b0) begin failures++; $display("FAIL rstmid_s_cyc got=%b exp=0", s_if.cyc); end
        checks++; if (s_if.stb !== 1'b0) begin failures++; $display("FAIL rstmid_s_stb got=%b exp=0", s_if.stb); end
        checks++; if (s_if.addr !== 30'h0) begin failures++; $display("FAIL rstmid_s_addr got=%h exp=0", s_if.addr); end
        checks++; if (m1_if.ack !== 1'b0) begin failures++; $display("FAIL rstmid_m1_ack got=%b exp=0", m1_if.ack); end
        tick();
        tick();
        s_if.ack = 0;
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 30'h0AA;
        rst = 1;
        @(negedge clk);
        checks++; if (s_if.cyc !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", s_if.cyc); end
        tick();
        @(negedge clk);
        checks++; if (s_if.cyc !== 1'b1) begin failures++; $display("FAIL rstmid_regrant_cyc got=%b exp=1", s_if.cyc); end
        checks++; if (s_if.addr !== 30'h0AA) begin failures++; $display("FAIL rstmid_regrant_addr got=%h exp=0aa", s_if.addr); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        logic [73:0] e_req, a_req;
        logic [4:0]  e_rsp, a_rsp;
        logic        e_fire;
        bit          calm;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            calm = ((c / 100) % 2) == 1;
            if (m0_if.cyc) begin
                if ($urandom_range(calm ? 29 : 5) == 0) m0_if.cyc = 0;
            end else if ($urandom_range(2) == 0) m0_if.cyc = 1;
            if (m1_if.cyc) begin
                if ($urandom_range(calm ? 29 : 5) == 0) m1_if.cyc = 0;
            end else if ($urandom_range(2) == 0) m1_if.cyc = 1;
            m0_if.stb = m0_if.cyc && (calm || $urandom_range(3) != 0);
            m1_if.stb = m1_if.cyc && (calm || $urandom_range(3) != 0);
            m0_if.we = 1'($urandom); m0_if.addr = 30'($urandom); m0_if.cti = 3'($urandom);
            m0_if.bte = 2'($urandom); m0_if.sel = 4'($urandom); m0_if.wdata = $urandom;
            m1_if.we = 1'($urandom); m1_if.addr = 30'($urandom); m1_if.cti = 3'($urandom);
            m1_if.bte = 2'($urandom); m1_if.sel = 4'($urandom); m1_if.wdata = $urandom;
            s_if.ack = ($urandom_range(calm ? 15 : 3) == 0);
            s_if.err = ($urandom_range(39) == 0);
            s_if.rdata = $urandom;
            @(negedge clk);
            if (owner == 0) e_req = {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.addr, m0_if.cti,
                                     m0_if.bte, m0_if.sel, m0_if.wdata};
            else if (owner == 1) e_req = {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.addr, m1_if.cti,
                                          m1_if.bte, m1_if.sel, m1_if.wdata};
            else e_req = '0;
            e_fire = mdl_fire();
            e_rsp = {owner == 0 && s_if.ack, owner == 0 && (s_if.err || e_fire),
                     owner == 1 && s_if.ack, owner == 1 && (s_if.err || e_fire), e_fire};
            a_req = {s_if.cyc, s_if.stb, s_if.we, s_if.addr, s_if.cti, s_if.bte, s_if.sel, s_if.wdata};
            a_rsp = {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, timeout};
            checks++; if (a_req !== e_req) begin failures++; $display("FAIL rand_req[%0d] got=%h exp=%h", c, a_req, e_req); end
            checks++; if (a_rsp !== e_rsp) begin failures++; $display("FAIL rand_rsp[%0d] got=%b exp=%b", c, a_rsp, e_rsp); end
            checks++; if ({m0_if.rdata, m1_if.rdata} !== {s_if.rdata, s_if.rdata}) begin
                failures++; $display("FAIL rand_rdata[%0d] got=%h/%h exp=%h", c, m0_if.rdata, m1_if.rdata, s_if.rdata);
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_burst();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
